clk_gate_ctrl: RTL

Activity-driven controller that produces the enable for the team's clock_gating cell.
- Keeps the gated clock running while there is work.
- Turns the clock off after a programmable idle timeout.
- On a new request, restarts the clock and asserts an acknowledge only after a settle window, so requesters never issue work into a stopped clock.
- Sits in the always-on domain, between the request sources and the clock_gating en_i input.

---
 rtl/clk_gate_defs.sv | 20 ++
 rtl/clk_gate_dncnt.sv | 39 +++
 rtl/clk_gate_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clk_gate_defs.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_defs (package)
//  Description : Shared definitions for the clock-gate enable controller:
//                state-register width and the four FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_gate_defs;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_RUN  = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

endpackage : clk_gate_defs
`default_nettype wire

// File: rtl/clk_gate_dncnt.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_dncnt
//  Description : Load/decrement down-counter shared by the idle-timeout and
//                wake-settle windows. Load has priority over decrement, and
//                the count stops at zero.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                load/load_val - synchronous load of a new window length
//                dec           - decrement request
//                zero          - counter currently holds zero
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_dncnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule : clk_gate_dncnt
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_ctrl
//  Description : Activity-driven enable generator for the clock_gating cell.
//                Keeps the gated clock running while there is work, stops it
//                after IDLE_CYCLES idle edges, and on a new request restarts
//                it, raising ack only WAKE_CYCLES edges after the enable.
//  Ports       : clk_i, rst_i  - free-running clock, async active-high reset
//                req_i         - new work request (always-on side)
//                busy_i        - gated-domain busy (ignored while OFF)
//                force_on_i    - software override holding the clock on
//                en_o          - registered enable to the clock gate
//                ack_o         - gated clock running and stable
//                state_o       - FSM state (debug)
//                wake_cnt_o    - saturating count of OFF->WAKE transitions
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl
    import clk_gate_defs::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int WCNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              busy_i,
    input  logic              force_on_i,
    output logic              en_o,
    output logic              ack_o,
    output logic [ST_W-1:0]   state_o,
    output logic [WCNT_W-1:0] wake_cnt_o
);

    localparam logic [CNT_W-1:0] c_idle_load = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wake_load = CNT_W'(WAKE_CYCLES - 1);

    state_t            r_state;
    logic              r_en;
    logic              r_ack;
    logic [WCNT_W-1:0] r_wake_cnt;

    logic              w_act;
    logic              w_wake;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    // busy_i has no meaning while the gated domain is stopped, so only
    // req_i and force_on_i can wake the clock.
    assign w_act  = req_i | busy_i | force_on_i;
    assign w_wake = req_i | force_on_i;

    // The idle and wake windows never overlap, so one counter serves both.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = c_idle_load;
        w_cnt_dec  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_cnt_load = ~w_act;
                w_cnt_val  = c_idle_load;
            end
            ST_IDLE: begin
                w_cnt_dec = ~w_act;
            end
            ST_OFF: begin
                w_cnt_load = w_wake;
                w_cnt_val  = c_wake_load;
            end
            ST_WAKE: begin
                w_cnt_dec = 1'b1;
            end
            default: begin
                w_cnt_load = 1'b0;
            end
        endcase
    end

    clk_gate_dncnt #(
        .CNT_W (CNT_W)
    ) u_dncnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    // Outputs are set alongside each state transition so en_o/ack_o come
    // straight from flops and only move on a rising clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_en       <= 1'b1;
            r_ack      <= 1'b1;
            r_wake_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // Activity outranks the timeout: a request on the final
                    // idle edge keeps the clock running.
                    if (w_act) begin
                        r_state <= ST_RUN;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_OFF;
                        r_en    <= 1'b0;
                        r_ack   <= 1'b0;
                    end
                end
                ST_OFF: begin
                    if (w_wake) begin
                        r_state <= ST_WAKE;
                        r_en    <= 1'b1;
                        if (r_wake_cnt != {WCNT_W{1'b1}}) begin
                            r_wake_cnt <= r_wake_cnt + 1'b1;
                        end
                    end
                end
                ST_WAKE: begin
                    // Never aborted; a dropped request simply times out
                    // later through IDLE.
                    if (w_cnt_zero) begin
                        r_state <= ST_RUN;
                        r_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_en    <= 1'b1;
                    r_ack   <= 1'b1;
                end
            endcase
        end
    end

    assign en_o       = r_en;
    assign ack_o      = r_ack;
    assign state_o    = r_state;
    assign wake_cnt_o = r_wake_cnt;

endmodule : clk_gate_ctrl
`default_nettype wire
